ram16k_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer that shares the single-port `ram16k` (16-bit words, 14-bit address) between two requesters, port A (CPU) and port B (loader/video). One accepted command per cycle is registered onto the RAM pins. Read data is returned to the issuing port at a fixed latency, tagged through an in-flight pipeline. Sits between the requesters and `ram16k`, which it drives directly.

---
 rtl/ram16k_arbiter_if.sv | 21 ++
 rtl/ram16k_arbiter.sv | 95 +++++++++
 tb/tb_ram16k_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram16k_arbiter_if.sv
// One requester port of the ram16k arbiter: command handshake plus tagged read return.
// The requester drives the master side; the arbiter is the slave.
interface ram16k_arbiter_if;
    logic        req;
    logic        we;
    logic [13:0] addr;
    logic [15:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [15:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ram16k_arbiter.sv
// Round-robin arbiter sharing the single-port ram16k between port A (CPU) and port B
// (loader/video). Registers one command per cycle onto the RAM pins and routes read data back.
module ram16k_arbiter #(
    parameter int READ_LATENCY = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    ram16k_arbiter_if.slave  a_port,
    ram16k_arbiter_if.slave  b_port,
    output logic             ram_load,
    output logic [13:0]      ram_address,
    output logic [15:0]      ram_in,
    input  logic [15:0]      ram_out
);

    // Tag reaches the output stage READ_LATENCY+1 edges after acceptance, lined up with ram_out.
    localparam int TAG_DEPTH = READ_LATENCY + 2;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    logic                 last;
    logic                 a_gnt;
    logic                 b_gnt;
    logic                 grant;
    logic                 sel_we;
    logic [13:0]          sel_addr;
    logic [15:0]          sel_wdata;
    logic                 rd_accept;
    logic [TAG_DEPTH-1:0] tag_valid;
    logic [TAG_DEPTH-1:0] tag_owner;
    logic                 a_rvalid;
    logic                 b_rvalid;

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (reset_n) begin
            if (a_port.req && (!b_port.req || last == OWNER_B)) begin
                a_gnt = 1'b1;
            end else if (b_port.req) begin
                b_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = ram_address;
        sel_wdata = ram_in;
        if (a_gnt) begin
            sel_we    = a_port.we;
            sel_addr  = a_port.addr;
            sel_wdata = a_port.wdata;
        end else if (b_gnt) begin
            sel_we    = b_port.we;
            sel_addr  = b_port.addr;
            sel_wdata = b_port.wdata;
        end
    end

    assign grant     = a_gnt | b_gnt;
    assign rd_accept = grant & ~sel_we;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ram_load    <= 1'b0;
            ram_address <= '0;
            ram_in      <= '0;
            last        <= OWNER_B;
            tag_valid   <= '0;
            tag_owner   <= '0;
        end else begin
            ram_load <= grant & sel_we;
            if (grant) begin
                ram_address <= sel_addr;
                ram_in      <= sel_wdata;
                last        <= b_gnt ? OWNER_B : OWNER_A;
            end
            tag_valid <= {tag_valid[TAG_DEPTH-2:0], rd_accept};
            tag_owner <= {tag_owner[TAG_DEPTH-2:0], b_gnt};
        end
    end

    assign a_rvalid = tag_valid[TAG_DEPTH-1] & (tag_owner[TAG_DEPTH-1] == OWNER_A);
    assign b_rvalid = tag_valid[TAG_DEPTH-1] & (tag_owner[TAG_DEPTH-1] == OWNER_B);

    assign a_port.gnt    = a_gnt;
    assign b_port.gnt    = b_gnt;
    assign a_port.rvalid = a_rvalid;
    assign b_port.rvalid = b_rvalid;
    assign a_port.rdata  = a_rvalid ? ram_out : '0;
    assign b_port.rdata  = b_rvalid ? ram_out : '0;

endmodule

// File: tb/tb_ram16k_arbiter.sv
// Directed bench for ram16k_arbiter: arbitration vector table plus hand-written
// sequences for latency, contention, streaming, reset mid-flight and idle.
module tb_ram16k_arbiter;

    localparam int READ_LATENCY = 2;

    logic        clock;
    logic        reset_n;
    logic        ram_load;
    logic [13:0] ram_address;
    logic [15:0] ram_in;
    logic [15:0] ram_out;

    ram16k_arbiter_if a_if ();
    ram16k_arbiter_if b_if ();

    ram16k_arbiter #(.READ_LATENCY(READ_LATENCY)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .a_port      (a_if),
        .b_port      (b_if),
        .ram_load    (ram_load),
        .ram_address (ram_address),
        .ram_in      (ram_in),
        .ram_out     (ram_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural RAM: data for the address seen in cycle k is on ram_out in cycle k+READ_LATENCY+1.
    logic [15:0] mem [0:16383];
    logic [15:0] rd_pipe [0:READ_LATENCY];

    always @(posedge clock) begin
        if (ram_load) mem[ram_address] <= ram_in;
        rd_pipe[0] <= mem[ram_address];
        for (int i = 1; i <= READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_out = rd_pipe[READ_LATENCY];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        a_req;
        logic        a_we;
        logic [13:0] a_addr;
        logic [15:0] a_wdata;
        logic        b_req;
        logic        b_we;
        logic [13:0] b_addr;
        logic [15:0] b_wdata;
        logic        exp_a_gnt;
        logic        exp_b_gnt;
        logic        exp_load;
        logic [13:0] exp_addr;
        logic [15:0] exp_in;
    } vec_t;

    vec_t vecs [11];

    task automatic drive_a(input logic req, input logic we, input logic [13:0] addr, input logic [15:0] wdata);
        a_if.req = req; a_if.we = we; a_if.addr = addr; a_if.wdata = wdata;
    endtask

    task automatic drive_b(input logic req, input logic we, input logic [13:0] addr, input logic [15:0] wdata);
        b_if.req = req; b_if.we = we; b_if.addr = addr; b_if.wdata = wdata;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        drive_a(1'b0, 1'b0, 14'h0, 16'h0);
        drive_b(1'b0, 1'b0, 14'h0, 16'h0);
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 14'h0010, 16'h0000, 1'b0, 1'b0, 14'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 14'h0010, 16'h0000};
        vecs[1]  = '{1'b1, 1'b1, 14'h0020, 16'h1111, 1'b1, 1'b0, 14'h0030, 16'h2222, 1'b0, 1'b1, 1'b0, 14'h0030, 16'h2222};
        vecs[2]  = '{1'b1, 1'b1, 14'h0020, 16'h1111, 1'b1, 1'b0, 14'h0038, 16'h2AAA, 1'b1, 1'b0, 1'b1, 14'h0020, 16'h1111};
        vecs[3]  = '{1'b0, 1'b0, 14'h0000, 16'h0000, 1'b1, 1'b0, 14'h0038, 16'h2AAA, 1'b0, 1'b1, 1'b0, 14'h0038, 16'h2AAA};
        vecs[4]  = '{1'b0, 1'b0, 14'h0000, 16'h0000, 1'b0, 1'b0, 14'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 14'h0038, 16'h2AAA};
        vecs[5]  = '{1'b0, 1'b0, 14'h0000, 16'h0000, 1'b1, 1'b1, 14'h0040, 16'h3333, 1'b0, 1'b1, 1'b1, 14'h0040, 16'h3333};
        vecs[6]  = '{1'b1, 1'b0, 14'h0060, 16'h4444, 1'b1, 1'b0, 14'h0070, 16'h5555, 1'b1, 1'b0, 1'b0, 14'h0060, 16'h4444};
        vecs[7]  = '{1'b1, 1'b0, 14'h0064, 16'h6666, 1'b1, 1'b0, 14'h0070, 16'h5555, 1'b0, 1'b1, 1'b0, 14'h0070, 16'h5555};
        vecs[8]  = '{1'b1, 1'b0, 14'h0064, 16'h6666, 1'b1, 1'b1, 14'h0074, 16'h7777, 1'b1, 1'b0, 1'b0, 14'h0064, 16'h6666};
        vecs[9]  = '{1'b0, 1'b0, 14'h0000, 16'h0000, 1'b1, 1'b1, 14'h0074, 16'h7777, 1'b0, 1'b1, 1'b1, 14'h0074, 16'h7777};
        vecs[10] = '{1'b0, 1'b0, 14'h0000, 16'h0000, 1'b0, 1'b0, 14'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 14'h0074, 16'h7777};

        // Reset with A already requesting: grant must stay low.
        reset_n = 1'b0;
        drive_a(1'b1, 1'b1, 14'h1234, 16'hBEEF);
        drive_b(1'b0, 1'b0, 14'h0, 16'h0);
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("gnt_in_reset", 32'(a_if.gnt), 32'd0);
            tick();
        end
        check("rst_load", 32'(ram_load), 32'd0);
        check("rst_addr", 32'(ram_address), 32'd0);
        check("rst_in", 32'(ram_in), 32'd0);
        check("rst_a_rvalid", 32'(a_if.rvalid), 32'd0);
        check("rst_b_rvalid", 32'(b_if.rvalid), 32'd0);
        reset_n = 1'b1;

        // Single write then read-after-write.
        @(negedge clock);
        check("wr_a_gnt", 32'(a_if.gnt), 32'd1);
        check("wr_b_gnt", 32'(b_if.gnt), 32'd0);
        tick();
        check("wr_load", 32'(ram_load), 32'd1);
        check("wr_addr", 32'(ram_address), 32'h1234);
        check("wr_in", 32'(ram_in), 32'hBEEF);
        drive_a(1'b1, 1'b0, 14'h1234, 16'h0000);
        @(negedge clock);
        check("raw_a_gnt", 32'(a_if.gnt), 32'd1);
        tick();
        drive_a(1'b0, 1'b0, 14'h0, 16'h0);
        check("raw_load_off", 32'(ram_load), 32'd0);
        check("raw_rvalid_e0", 32'(a_if.rvalid), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("raw_a_rvalid_%0d", k), 32'(a_if.rvalid), 32'(k == READ_LATENCY + 1));
            check($sformatf("raw_b_rvalid_%0d", k), 32'(b_if.rvalid), 32'd0);
            if (k == READ_LATENCY + 1) check("raw_a_rdata", 32'(a_if.rdata), 32'hBEEF);
        end

        // Arbitration vector table.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive_a(vecs[i].a_req, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_wdata);
            drive_b(vecs[i].b_req, vecs[i].b_we, vecs[i].b_addr, vecs[i].b_wdata);
            @(negedge clock);
            check($sformatf("vec%0d_a_gnt", i), 32'(a_if.gnt), 32'(vecs[i].exp_a_gnt));
            check($sformatf("vec%0d_b_gnt", i), 32'(b_if.gnt), 32'(vecs[i].exp_b_gnt));
            tick();
            check($sformatf("vec%0d_load", i), 32'(ram_load), 32'(vecs[i].exp_load));
            check($sformatf("vec%0d_addr", i), 32'(ram_address), 32'(vecs[i].exp_addr));
            check($sformatf("vec%0d_in", i), 32'(ram_in), 32'(vecs[i].exp_in));
        end

        // Preload two words, then contention straight after reset.
        drive_a(1'b1, 1'b1, 14'h0001, 16'hA001);
        tick();
        drive_a(1'b0, 1'b0, 14'h0, 16'h0);
        drive_b(1'b1, 1'b1, 14'h0002, 16'hB002);
        tick();
        do_reset();
        for (int k = 0; k < 9; k++) begin
            if (k < 4) begin
                drive_a(1'b1, 1'b0, 14'h0001, 16'h0);
                drive_b(1'b1, 1'b0, 14'h0002, 16'h0);
            end else begin
                drive_a(1'b0, 1'b0, 14'h0, 16'h0);
                drive_b(1'b0, 1'b0, 14'h0, 16'h0);
            end
            @(negedge clock);
            check($sformatf("cont_a_gnt_%0d", k), 32'(a_if.gnt), 32'(k < 4 && (k % 2) == 0));
            check($sformatf("cont_b_gnt_%0d", k), 32'(b_if.gnt), 32'(k < 4 && (k % 2) == 1));
            tick();
            check($sformatf("cont_a_rvalid_%0d", k), 32'(a_if.rvalid), 32'(k == 3 || k == 5));
            check($sformatf("cont_b_rvalid_%0d", k), 32'(b_if.rvalid), 32'(k == 4 || k == 6));
            check($sformatf("cont_a_rdata_%0d", k), 32'(a_if.rdata), (k == 3 || k == 5) ? 32'hA001 : 32'h0);
            check($sformatf("cont_b_rdata_%0d", k), 32'(b_if.rdata), (k == 4 || k == 6) ? 32'hB002 : 32'h0);
        end

        // Streaming: 8 writes then 8 reads on B with no bubbles.
        for (int k = 0; k < 20; k++) begin
            if (k < 8)       drive_b(1'b1, 1'b1, 14'(k), 16'(16'h0100 + k));
            else if (k < 16) drive_b(1'b1, 1'b0, 14'(k - 8), 16'h0);
            else             drive_b(1'b0, 1'b0, 14'h0, 16'h0);
            @(negedge clock);
            check($sformatf("strm_b_gnt_%0d", k), 32'(b_if.gnt), 32'(k < 16));
            tick();
            check($sformatf("strm_b_rvalid_%0d", k), 32'(b_if.rvalid), 32'(k >= 11 && k <= 18));
            check($sformatf("strm_a_rvalid_%0d", k), 32'(a_if.rvalid), 32'd0);
            if (k >= 11 && k <= 18)
                check($sformatf("strm_b_rdata_%0d", k), 32'(b_if.rdata), 32'h0100 + 32'(k - 11));
        end

        // Reset one cycle after a read grant: the read must vanish.
        drive_a(1'b1, 1'b0, 14'h1234, 16'h0);
        @(negedge clock);
        check("mid_a_gnt", 32'(a_if.gnt), 32'd1);
        tick();
        reset_n = 1'b0;
        @(negedge clock);
        check("mid_gnt_forced", 32'(a_if.gnt), 32'd0);
        tick();
        reset_n = 1'b1;
        drive_a(1'b0, 1'b0, 14'h0, 16'h0);
        check("mid_rvalid_0", 32'(a_if.rvalid), 32'd0);
        for (int k = 1; k < 7; k++) begin
            tick();
            check($sformatf("mid_rvalid_%0d", k), 32'(a_if.rvalid), 32'd0);
        end
        drive_a(1'b1, 1'b0, 14'h0ABC, 16'h0);
        drive_b(1'b1, 1'b0, 14'h0DEF, 16'h0);
        @(negedge clock);
        check("mid_cont_a_gnt", 32'(a_if.gnt), 32'd1);
        check("mid_cont_b_gnt", 32'(b_if.gnt), 32'd0);
        tick();
        drive_a(1'b0, 1'b0, 14'h0, 16'h0);
        @(negedge clock);
        check("mid_cont_b_next", 32'(b_if.gnt), 32'd1);
        tick();
        drive_b(1'b0, 1'b0, 14'h0, 16'h0);
        repeat (6) tick();

        // Idle: nothing moves, address holds.
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check($sformatf("idle_a_gnt_%0d", k), 32'(a_if.gnt), 32'd0);
            check($sformatf("idle_b_gnt_%0d", k), 32'(b_if.gnt), 32'd0);
            tick();
            check($sformatf("idle_load_%0d", k), 32'(ram_load), 32'd0);
            check($sformatf("idle_addr_%0d", k), 32'(ram_address), 32'h0DEF);
            check($sformatf("idle_rvalid_%0d", k), 32'(a_if.rvalid | b_if.rvalid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
